cache_fill_unit: RTL and testbench
==================================

# cache_fill_unit

Miss-handling stage that sits directly upstream of the cache line storage array. It accepts a miss address from the lookup logic and issues a line-aligned read to memory. When the line returns, it writes tag, data and valid into one victim line, chosen round-robin across a fully associative array. It also performs a whole-cache invalidate on request.

## Interface
- ADDR_W, 32, address width in bits
- LINE_BYTES, 64, cache line size in bytes; OFF_BITS = log2(LINE_BYTES) = 6
- LINE_W, 512, line data width in bits (LINE_BYTES*8)
- NUM_LINES, 4, number of cache lines driven (power of two, ≥2)
- TAG_W, ADDR_W-OFF_BITS (26), tag width
- One clock; reset is asynchronous and active-high (ports `clk`, `reset`).
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- miss_valid  in  1  miss request present
- miss_addr  in  ADDR_W  byte address that missed
- miss_ready  out  1  unit can accept a miss this cycle
- flush  in  1  request invalidate of all lines
- mem_req_valid  out  1  memory read request valid
- mem_req_addr  out  ADDR_W  line-aligned read address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  line data returned (single-cycle pulse)
- mem_resp_data  in  LINE_W  returned line
- line_overwrite  out  NUM_LINES  one-hot/all-ones write enable to line array
- line_valid  out  1  valid bit written to selected line(s)
- line_tag  out  TAG_W  tag written
- line_data  out  LINE_W  data written
- fill_done  out  1  one-cycle pulse when a fill is written
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, FILL, FLUSH.
- IDLE:
  - miss_ready = !flush.
  - flush=1 → FLUSH; flush has priority over a simultaneous miss_valid.
  - miss_valid && miss_ready → capture tag = miss_addr[ADDR_W-1:OFF_BITS], go REQ.
- REQ:
  - mem_req_valid=1, mem_req_addr = {tag, OFF_BITS'b0}, held stable until mem_req_ready.
  - mem_req_ready=1 → WAIT.
- WAIT:
  - On mem_resp_valid, capture mem_resp_data, go FILL.
  - Memory latency is unbounded; no timeout.
- FILL (exactly one cycle):
  - line_overwrite = one-hot(victim_ptr), line_valid=1, line_tag=tag, line_data=captured data, fill_done=1.
  - victim_ptr increments modulo NUM_LINES (NUM_LINES-1 → 0).
  - Go IDLE.
- FLUSH (exactly one cycle):
  - line_overwrite = all ones, line_valid=0, line_tag=0, line_data=0.
  - victim_ptr ← 0; go IDLE.
- Outside FILL/FLUSH: line_overwrite=0, fill_done=0. line_tag, line_data and line_valid are don't-care there but are driven to 0.
- mem_resp_valid outside WAIT is ignored and the data is dropped.
- flush outside IDLE is ignored; the requester holds flush until busy=0.
- miss_valid outside IDLE is ignored (miss_ready=0).
- The unit holds only one outstanding miss; there is no duplicate-tag check, which is the requester's responsibility.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, victim_ptr=0, tag=0, data=0.
  - All outputs 0, except miss_ready = !flush.
- Reset mid-operation aborts any fill with no line write. An outstanding memory response after reset is ignored (the unit is in IDLE).
- All outputs except miss_ready are registered-state functions, so there is no input→output combinational path except flush→miss_ready.
- Minimum miss latency, miss accepted at cycle 0:
  - REQ in cycle 1; mem_req_ready=1 in cycle 1 → WAIT in cycle 2.
  - mem_resp_valid in cycle 2 → FILL/fill_done in cycle 3.
  - IDLE in cycle 4; the next miss can be accepted in cycle 4.
- Each mem_req_ready stall cycle or response wait cycle adds one cycle.
- Flush: accepted at cycle 0, FLUSH write in cycle 1, IDLE in cycle 2.
- The line array samples line_* at the same rising edge that ends FILL/FLUSH.

## Test plan
- Reset then single miss:
  - Stimulus: miss_addr=0x0000_1234; mem_req_ready=1; response data = 512'hA5…A5 two cycles after request.
  - Required: mem_req_addr=0x0000_1200.
  - Required: line_overwrite=4'b0001, line_tag=26'h48, line_valid=1, fill_done pulses one cycle.
- Round-robin wrap: five back-to-back misses.
  - Required: line_overwrite sequence 0001, 0010, 0100, 1000, 0001.
- Backpressure: mem_req_ready held 0 for 3 cycles.
  - Required: mem_req_valid=1 and mem_req_addr stable all 4 cycles; exactly one request accepted.
- Flush vs miss, same IDLE cycle:
  - Required: miss_ready=0; next cycle line_overwrite=4'b1111, line_valid=0.
  - Required: after that, the miss is accepted and fills line 0 (pointer reset).
- Spurious and late responses:
  - mem_resp_valid in IDLE → no line write.
  - Reset asserted in WAIT, then response arrives → no line write, busy=0.
- Miss held during fill: miss_valid=1 throughout a fill → miss_ready=0 until IDLE, then accepted the cycle after FILL.

Source files
------------

// File: rtl/cache_fill_unit.sv
// ============================================================================
// cache_fill_unit: line fill on miss with round-robin victim, plus flush.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_fill_unit #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int LINE_W     = LINE_BYTES * 8,
  parameter int NUM_LINES  = 4,
  parameter int TAG_W      = ADDR_W - $clog2(LINE_BYTES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 miss_valid,
  input  logic [ADDR_W-1:0]    miss_addr,
  output logic                 miss_ready,
  input  logic                 flush,
  output logic                 mem_req_valid,
  output logic [ADDR_W-1:0]    mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  logic [LINE_W-1:0]    mem_resp_data,
  output logic [NUM_LINES-1:0] line_overwrite,
  output logic                 line_valid,
  output logic [TAG_W-1:0]     line_tag,
  output logic [LINE_W-1:0]    line_data,
  output logic                 fill_done,
  output logic                 busy
);

  localparam int OFF_BITS = $clog2(LINE_BYTES);
  localparam int PTR_W    = $clog2(NUM_LINES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FILL  = 3'd3,
    S_FLUSH = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]    mem_req_addr_q, mem_req_addr_d;
  logic [NUM_LINES-1:0] line_overwrite_q, line_overwrite_d;
  logic                 line_valid_q, line_valid_d;
  logic [TAG_W-1:0]     line_tag_q, line_tag_d;
  logic [LINE_W-1:0]    line_data_q, line_data_d;
  logic                 fill_done_q, fill_done_d;
  logic                 busy_q, busy_d;

  // Byte-offset bits of the miss address never matter for a line fill.
  logic unused_offset;
  assign unused_offset = ^miss_addr[OFF_BITS-1:0];

  assign miss_ready = (state_q == S_IDLE) && !flush;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_FLUSH;
        end else if (miss_valid) begin
          state_d = S_REQ;
          tag_d   = miss_addr[ADDR_W-1:OFF_BITS];
        end
      end
      S_REQ:   if (mem_req_ready) state_d = S_WAIT;
      S_WAIT:  if (mem_resp_valid) state_d = S_FILL;
      S_FILL: begin
        ptr_d   = ptr_q + PTR_W'(1);
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        ptr_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered by decoding the state being entered; the returned
  // line goes straight into the line_data register, which doubles as capture.
  always_comb begin
    mem_req_valid_d  = 1'b0;
    mem_req_addr_d   = '0;
    line_overwrite_d = '0;
    line_valid_d     = 1'b0;
    line_tag_d       = '0;
    line_data_d      = '0;
    fill_done_d      = 1'b0;
    busy_d           = (state_d != S_IDLE);
    case (state_d)
      S_REQ: begin
        mem_req_valid_d = 1'b1;
        mem_req_addr_d  = {tag_d, {OFF_BITS{1'b0}}};
      end
      S_FILL: begin
        line_overwrite_d = NUM_LINES'(1) << ptr_q;
        line_valid_d     = 1'b1;
        line_tag_d       = tag_q;
        line_data_d      = mem_resp_data;
        fill_done_d      = 1'b1;
      end
      S_FLUSH: line_overwrite_d = '1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      tag_q            <= '0;
      ptr_q            <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_req_addr_q   <= '0;
      line_overwrite_q <= '0;
      line_valid_q     <= 1'b0;
      line_tag_q       <= '0;
      line_data_q      <= '0;
      fill_done_q      <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      tag_q            <= tag_d;
      ptr_q            <= ptr_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_req_addr_q   <= mem_req_addr_d;
      line_overwrite_q <= line_overwrite_d;
      line_valid_q     <= line_valid_d;
      line_tag_q       <= line_tag_d;
      line_data_q      <= line_data_d;
      fill_done_q      <= fill_done_d;
      busy_q           <= busy_d;
    end
  end

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = mem_req_addr_q;
  assign line_overwrite = line_overwrite_q;
  assign line_valid     = line_valid_q;
  assign line_tag       = line_tag_q;
  assign line_data      = line_data_q;
  assign fill_done      = fill_done_q;
  assign busy           = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_fill_unit.sv
// ============================================================================
// tb_cache_fill_unit: transaction-level model plus directed miss/flush vectors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_fill_unit;

  localparam int NL = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         miss_valid = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         miss_ready;
  logic         flush = 1'b0;
  logic         mem_req_valid;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready = 1'b0;
  logic         mem_resp_valid = 1'b0;
  logic [511:0] mem_resp_data = '0;
  logic [3:0]   line_overwrite;
  logic         line_valid;
  logic [25:0]  line_tag;
  logic [511:0] line_data;
  logic         fill_done;
  logic         busy;

  cache_fill_unit dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .line_overwrite(line_overwrite), .line_valid(line_valid),
    .line_tag(line_tag), .line_data(line_data),
    .fill_done(fill_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: an outstanding miss is either waiting for its
  // request to be taken, waiting for data, or holding data to be written.
  logic         m_have_miss = 1'b0, m_req_sent = 1'b0, m_line_ready = 1'b0;
  logic         m_flushing = 1'b0;
  logic [25:0]  m_tag = '0;
  logic [511:0] m_data = '0;
  int           m_fills = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_have_miss <= 1'b0; m_req_sent <= 1'b0; m_line_ready <= 1'b0;
      m_flushing <= 1'b0; m_tag <= '0; m_data <= '0; m_fills <= 0;
    end else if (m_flushing) begin
      m_flushing <= 1'b0;
      m_fills <= 0;
    end else if (m_line_ready) begin
      m_line_ready <= 1'b0; m_have_miss <= 1'b0; m_req_sent <= 1'b0;
      m_fills <= m_fills + 1;
    end else if (m_have_miss && !m_req_sent) begin
      if (mem_req_ready) m_req_sent <= 1'b1;
    end else if (m_have_miss) begin
      if (mem_resp_valid) begin
        m_data <= mem_resp_data;
        m_line_ready <= 1'b1;
      end
    end else if (flush) begin
      m_flushing <= 1'b1;
    end else if (miss_valid) begin
      m_have_miss <= 1'b1;
      m_tag <= miss_addr[31:6];
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_ow;
    exp_ow = m_line_ready ? 4'(1 << (m_fills % NL)) : (m_flushing ? 4'hF : 4'h0);
    chk("miss_ready", miss_ready, !m_have_miss && !m_flushing && !flush);
    chk("busy", busy, m_have_miss || m_flushing);
    chk("mem_req_valid", mem_req_valid, m_have_miss && !m_req_sent);
    if (m_have_miss && !m_req_sent) chk("mem_req_addr", mem_req_addr, {m_tag, 6'b0});
    chk("line_overwrite", line_overwrite, exp_ow);
    chk("line_valid", line_valid, m_line_ready);
    chk("line_tag", line_tag, m_line_ready ? m_tag : 26'h0);
    chk("line_data", line_data, m_line_ready ? m_data : 512'h0);
    chk("fill_done", fill_done, m_line_ready);
  end

  // Event log used for the literal expectations at the end.
  logic [3:0]  ow_log [$];
  logic [25:0] tag_log [$];
  logic [31:0] req_log [$];
  int          done_cnt = 0;
  int          req_valid_cycles = 0;

  always @(negedge clk) begin
    if (line_overwrite != 4'h0) begin
      ow_log.push_back(line_overwrite);
      tag_log.push_back(line_tag);
    end
    if (mem_req_valid && mem_req_ready) req_log.push_back(mem_req_addr);
    if (fill_done) done_cnt++;
    if (mem_req_valid) req_valid_cycles++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_miss(input logic [31:0] addr, input int stall, input int lat,
                         input logic [511:0] data);
    miss_valid = 1'b1; miss_addr = addr;
    cyc();
    miss_valid = 1'b0;
    repeat (stall) cyc();
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    repeat (lat) cyc();
    mem_resp_valid = 1'b1; mem_resp_data = data;
    cyc();
    mem_resp_valid = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rv0;
    logic [3:0]  exp_ow  [10];
    logic [31:0] exp_req [10];
    exp_ow  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'hF, 4'h1, 4'h1, 4'h2};
    exp_req = '{32'h1200, 32'h2000, 32'h3040, 32'h4080, 32'h50C0,
                32'h6000, 32'h7000, 32'h8000, 32'h9000, 32'hA000};

    #1 reset = 1'b1;
    repeat (3) cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_overwrite", line_overwrite, 4'h0);
    chk("rst_miss_ready", miss_ready, 1'b1);
    reset = 1'b0;
    cyc();

    // Single miss, response two cycles after the request is taken.
    do_miss(32'h0000_1234, 0, 1, {16{32'hA5A5_A5A5}});

    // Four more back-to-back misses, wrapping the victim pointer.
    do_miss(32'h0000_2000, 0, 0, {16{32'h1111_1111}});
    do_miss(32'h0000_3040, 0, 2, {16{32'h2222_2222}});
    do_miss(32'h0000_4080, 0, 0, {16{32'h3333_3333}});
    do_miss(32'h0000_50C0, 0, 0, {16{32'h4444_4444}});

    // Request backpressure for three cycles.
    rv0 = req_valid_cycles;
    do_miss(32'h0000_6000, 3, 0, {16{32'hDEAD_BEEF}});
    chk("bp_req_valid_cycles", 32'(req_valid_cycles - rv0), 32'd4);

    // Flush and miss presented together in IDLE.
    flush = 1'b1; miss_valid = 1'b1; miss_addr = 32'h0000_7000;
    #1;
    chk("flush_miss_ready", miss_ready, 1'b0);
    cyc();
    chk("flush_overwrite", line_overwrite, 4'hF);
    chk("flush_valid", line_valid, 1'b0);
    cyc();
    flush = 1'b0;
    do_miss(32'h0000_7000, 0, 0, {16{32'h7777_7777}});

    // Spurious response while idle.
    mem_resp_valid = 1'b1; mem_resp_data = {16{32'hBAD0_BAD0}};
    cyc();
    mem_resp_valid = 1'b0;
    cyc();
    chk("spurious_overwrite", line_overwrite, 4'h0);

    // Reset while waiting for data, then the late response.
    miss_valid = 1'b1; miss_addr = 32'h0000_8000;
    cyc();
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = {16{32'hFEED_FACE}};
    cyc();
    mem_resp_valid = 1'b0;
    chk("late_busy", busy, 1'b0);
    chk("late_overwrite", line_overwrite, 4'h0);
    cyc();

    // Miss held high across a whole fill.
    miss_valid = 1'b1; miss_addr = 32'h0000_9000;
    cyc();
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = {16{32'h0909_0909}};
    cyc();
    mem_resp_valid = 1'b0;
    chk("held_fill_done", fill_done, 1'b1);
    chk("held_miss_ready_fill", miss_ready, 1'b0);
    miss_addr = 32'h0000_A000;
    cyc();
    chk("held_miss_ready_idle", miss_ready, 1'b1);
    cyc();
    miss_valid = 1'b0;
    chk("held_second_req", mem_req_valid, 1'b1);
    chk("held_second_addr", mem_req_addr, 32'h0000_A000);
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    cyc();
    mem_resp_valid = 1'b1; mem_resp_data = {16{32'h0A0A_0A0A}};
    cyc();
    mem_resp_valid = 1'b0;
    cyc();
    cyc();

    // Literal expectations over the whole run.
    chk("n_line_writes", 32'(ow_log.size()), 32'd10);
    chk("n_requests", 32'(req_log.size()), 32'd10);
    chk("n_fill_done", 32'(done_cnt), 32'd9);
    for (int i = 0; i < 10; i++) begin
      if (i < ow_log.size()) chk($sformatf("ow_seq[%0d]", i), ow_log[i], exp_ow[i]);
      if (i < req_log.size()) chk($sformatf("req_addr[%0d]", i), req_log[i], exp_req[i]);
    end
    if (tag_log.size() > 1) begin
      chk("first_tag", tag_log[0], 26'h48);
      chk("second_tag", tag_log[1], 26'h80);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
